param_flash_loader: RTL and testbench
=====================================

PARAM_FLASH_LOADER -- requirements
Module: param_flash_loader

Interface
REQ-001 FLASH_BASE_ADDR, 24'h0F0000, byte address of the parameter block in SPI flash.
REQ-002 WORD_NUM, 16, number of 16-bit parameter words copied to SRAM; legal range 1..256.
REQ-003 SCK_DIV, 2, SCK half-period in i_clk_50m cycles; legal range 1..255.
REQ-004 i_clk_50m  in  1  single system clock; all logic on its rising edge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_load_start  in  1  single-cycle request to copy the parameter block from flash to SRAM.
REQ-007 o_spi_cs_n  out  1  flash chip select, active low.
REQ-008 o_spi_sck  out  1  flash clock, SPI mode 0, idle low.
REQ-009 o_spi_mosi  out  1  flash serial data out.
REQ-010 i_spi_miso  in  1  flash serial data in.
REQ-011 o_sram_csen  out  1  SRAM select, active high.
REQ-012 o_sram_wren  out  1  SRAM write enable, active low.
REQ-013 o_sram_rden  out  1  SRAM read enable, active low; held at 1.
REQ-014 o_sram_addr  out  18  SRAM word address.
REQ-015 o_sram_data  out  16  SRAM write data.
REQ-016 o_read_complete_sig  out  1  one-cycle pulse: all words are in SRAM addresses 0..WORD_NUM-1.
REQ-017 o_busy  out  1  high from the accepted start until the DONE or ERR cycle inclusive.
REQ-018 o_cks_err  out  1  sticky checksum failure flag.

Function
REQ-019 States SHALL be IDLE, CMD, RDATA, WRITE, NEXT, DONE, ERR; the encoding is one-hot and any illegal state returns to IDLE.
REQ-020 IDLE: i_load_start=1 clears o_cks_err and the word index, loads the 32-bit shift word {8'h03, FLASH_BASE_ADDR}, drives o_spi_cs_n low on the next cycle, and moves to CMD; i_load_start is ignored in every other state.
REQ-021 SCK timing: each SCK phase (low, then high) lasts SCK_DIV cycles; MOSI updates at the SCK falling edge (the first bit is valid when CS falls); MISO is sampled on the cycle SCK rises.
REQ-022 CMD shifts 32 bits MSB first, then goes to RDATA; MOSI is don't-care in RDATA and driven 0.
REQ-023 RDATA shifts in 16 bits MSB first (flash byte n = high byte, byte n+1 = low byte), then goes to WRITE with SCK held low.
REQ-024 WRITE lasts exactly 1 cycle: o_sram_csen=1, o_sram_wren=0, o_sram_addr=word index, o_sram_data=assembled word.
REQ-025 NEXT: csen=0, wren=1; if the last data word is done, go to DONE, else increment the index and go to RDATA; CS stays low, forming one continuous flash read.
REQ-026 DONE: o_spi_cs_n=1, o_read_complete_sig=1 for exactly one cycle, then IDLE.
REQ-027 Outside WRITE: o_sram_csen=0, o_sram_wren=1, o_sram_addr=0, o_sram_data=0.
REQ-028 Total latency from start to the complete pulse, without checksum, is 1 + 64*SCK_DIV + WORD_NUM*(32*SCK_DIV+2) cycles, +/-2.
REQ-029 The word index is 18 bits wide, so no wrap occurs within the legal WORD_NUM range.

Reset
REQ-030 i_rst=1 at any clock forces, on that edge: state IDLE, o_spi_cs_n=1, o_spi_sck=0, o_spi_mosi=0, o_sram_csen=0, o_sram_wren=1, o_sram_rden=1, o_sram_addr=0, o_sram_data=0, o_read_complete_sig=0, o_busy=0, o_cks_err=0.
REQ-031 A reset during a transfer SHALL abort it with no complete pulse; i_load_start coincident with i_rst is ignored.

Configuration
REQ-032 With PARAM_CHECKSUM_EN defined: after WORD_NUM words, one extra word is read and not written to SRAM; the 16-bit modular sum of all data words plus this word must equal 16'h0000, else the block goes to ERR.
REQ-033 ERR drives CS high, sets o_cks_err=1, asserts no complete pulse, and returns to IDLE; latency grows by 32*SCK_DIV cycles.
REQ-034 Without PARAM_CHECKSUM_EN: no checksum word is read, ERR is unreachable, and o_cks_err is tied 0.

Verification
REQ-035 Defaults, flash model holding 0x0001,0x1234,...: start -> MOSI carries 0x030F0000; SRAM writes addr0=0x0001, addr1=0x1234 ... addr15; one complete pulse.
REQ-036 WORD_NUM=1, SCK_DIV=1: start -> exactly one WRITE at addr 0; complete pulse at 1+64+34 cycles (+/-2).
REQ-037 Second i_load_start mid-CMD -> ignored, exactly 16 writes, single pulse.
REQ-038 i_rst asserted during word 5 -> next edge CS=1, SCK=0, wren=1, no pulse; a new start then copies all 16 words correctly.
REQ-039 PARAM_CHECKSUM_EN, words 0x0001,0x0002 (WORD_NUM=2), cks 0xFFFD -> complete pulse, o_cks_err=0; cks 0xFFFC -> o_cks_err=1, no pulse, 2 writes only.

Source files
------------

// File: rtl/param_flash_loader_if.sv
`timescale 1ns/1ps
// Pin bundle between the parameter loader, the SPI flash and the SRAM write port.
// The master side is the loader; the slave side is the flash/SRAM pair.
interface param_flash_loader_if;
  logic        o_spi_cs_n;
  logic        o_spi_sck;
  logic        o_spi_mosi;
  logic        i_spi_miso;
  logic        o_sram_csen;
  logic        o_sram_wren;
  logic        o_sram_rden;
  logic [17:0] o_sram_addr;
  logic [15:0] o_sram_data;

  modport master (
    output o_spi_cs_n, o_spi_sck, o_spi_mosi,
    input  i_spi_miso,
    output o_sram_csen, o_sram_wren, o_sram_rden, o_sram_addr, o_sram_data
  );

  modport slave (
    input  o_spi_cs_n, o_spi_sck, o_spi_mosi,
    output i_spi_miso,
    input  o_sram_csen, o_sram_wren, o_sram_rden, o_sram_addr, o_sram_data
  );
endinterface

// File: rtl/param_flash_loader.sv
`timescale 1ns/1ps
// Copies WORD_NUM 16-bit words from SPI flash (one continuous 0x03 read) into SRAM 0..WORD_NUM-1.
// Define PARAM_CHECKSUM_EN to read one trailing checksum word and flag a nonzero block sum.
module param_flash_loader #(
  parameter logic [23:0] FLASH_BASE_ADDR = 24'h0F0000,
  parameter int          WORD_NUM        = 16,
  parameter int          SCK_DIV         = 2
) (
  input  logic                        i_clk_50m,
  input  logic                        i_rst,
  input  logic                        i_load_start,
  param_flash_loader_if.master        bus,
  output logic                        o_read_complete_sig,
  output logic                        o_busy,
  output logic                        o_cks_err
);

  typedef enum logic [6:0] {
    IDLE  = 7'b0000001,
    CMD   = 7'b0000010,
    RDATA = 7'b0000100,
    WRITE = 7'b0001000,
    NEXT  = 7'b0010000,
    DONE  = 7'b0100000,
    ERR   = 7'b1000000
  } state_t;

  localparam logic [31:0] CMD_WORD = {8'h03, FLASH_BASE_ADDR};
  localparam logic [17:0] LAST_IDX = 18'(WORD_NUM - 1);
  localparam logic [7:0]  DIV_LAST = 8'(SCK_DIV - 1);

  state_t      state_reg, state_next;
  logic [31:0] shift_reg;
  logic [15:0] data_reg;
  logic [17:0] idx_reg;
  logic [7:0]  div_reg;
  logic [4:0]  bit_reg;
  logic        sck_reg;
  logic        cs_n_reg;
  logic        csen_reg;
  logic        wren_reg;
  logic [17:0] addr_reg;
  logic [15:0] wdata_reg;
  logic        complete_reg;
  logic        busy_reg;

  logic phase_end, sck_rise, sck_fall, last_bit, last_word, spi_active;

  assign phase_end  = (div_reg == DIV_LAST);
  assign sck_rise   = phase_end & ~sck_reg;
  assign sck_fall   = phase_end &  sck_reg;
  assign last_bit   = (state_reg == CMD) ? (bit_reg == 5'd31) : (bit_reg == 5'd15);
  assign last_word  = (idx_reg == LAST_IDX);
  assign spi_active = (state_reg == CMD) || (state_reg == RDATA);

`ifdef PARAM_CHECKSUM_EN
  logic [15:0] sum_reg;
  logic [15:0] cks_total;
  logic        cks_phase_reg;
  logic        cks_err_reg;
  assign cks_total = sum_reg + data_reg;
`endif

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (i_load_start) state_next = CMD;
      CMD:   if (sck_fall && last_bit) state_next = RDATA;
      RDATA: if (sck_fall && last_bit) begin
`ifdef PARAM_CHECKSUM_EN
        if (cks_phase_reg) state_next = (cks_total == 16'h0000) ? DONE : ERR;
        else               state_next = WRITE;
`else
        state_next = WRITE;
`endif
      end
      WRITE: state_next = NEXT;
      NEXT: begin
`ifdef PARAM_CHECKSUM_EN
        state_next = RDATA;
`else
        state_next = last_word ? DONE : RDATA;
`endif
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pin-level outputs are registered from state_next so they line up with the state they describe.
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      shift_reg    <= '0;
      data_reg     <= '0;
      idx_reg      <= '0;
      div_reg      <= '0;
      bit_reg      <= '0;
      sck_reg      <= 1'b0;
      cs_n_reg     <= 1'b1;
      csen_reg     <= 1'b0;
      wren_reg     <= 1'b1;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      complete_reg <= 1'b0;
      busy_reg     <= 1'b0;
`ifdef PARAM_CHECKSUM_EN
      sum_reg       <= '0;
      cks_phase_reg <= 1'b0;
      cks_err_reg   <= 1'b0;
`endif
    end else begin
      cs_n_reg     <= !((state_next == CMD) || (state_next == RDATA) ||
                        (state_next == WRITE) || (state_next == NEXT));
      busy_reg     <= (state_next != IDLE);
      complete_reg <= (state_next == DONE);
      csen_reg     <= (state_next == WRITE);
      wren_reg     <= (state_next != WRITE);
      addr_reg     <= (state_next == WRITE) ? idx_reg  : '0;
      wdata_reg    <= (state_next == WRITE) ? data_reg : '0;

      if (spi_active) begin
        if (phase_end) begin
          div_reg <= '0;
          sck_reg <= ~sck_reg;
        end else begin
          div_reg <= div_reg + 8'd1;
        end
        if (sck_rise && state_reg == RDATA) data_reg <= {data_reg[14:0], bus.i_spi_miso};
        if (sck_fall) begin
          // Shifting zeros in leaves MOSI low once the command has gone out.
          shift_reg <= {shift_reg[30:0], 1'b0};
          bit_reg   <= last_bit ? 5'd0 : bit_reg + 5'd1;
        end
      end

      case (state_reg)
        IDLE: if (i_load_start) begin
          shift_reg <= CMD_WORD;
          idx_reg   <= '0;
          div_reg   <= '0;
          bit_reg   <= '0;
          sck_reg   <= 1'b0;
`ifdef PARAM_CHECKSUM_EN
          sum_reg       <= '0;
          cks_phase_reg <= 1'b0;
          cks_err_reg   <= 1'b0;
`endif
        end
        WRITE: begin
`ifdef PARAM_CHECKSUM_EN
          sum_reg <= sum_reg + data_reg;
`endif
        end
        NEXT: begin
          if (!last_word) idx_reg <= idx_reg + 18'd1;
`ifdef PARAM_CHECKSUM_EN
          else            cks_phase_reg <= 1'b1;
`endif
        end
        CMD, RDATA, DONE, ERR: ;
        default: begin
          shift_reg <= '0;
          sck_reg   <= 1'b0;
        end
      endcase

`ifdef PARAM_CHECKSUM_EN
      if (state_next == ERR) cks_err_reg <= 1'b1;
`endif
    end
  end

  assign bus.o_spi_cs_n      = cs_n_reg;
  assign bus.o_spi_sck       = sck_reg;
  assign bus.o_spi_mosi      = shift_reg[31];
  assign bus.o_sram_csen     = csen_reg;
  assign bus.o_sram_wren     = wren_reg;
  assign bus.o_sram_rden     = 1'b1;
  assign bus.o_sram_addr     = addr_reg;
  assign bus.o_sram_data     = wdata_reg;
  assign o_read_complete_sig = complete_reg;
  assign o_busy              = busy_reg;
`ifdef PARAM_CHECKSUM_EN
  assign o_cks_err = cks_err_reg;
`else
  assign o_cks_err = 1'b0;
`endif

endmodule

// File: tb/tb_param_flash_loader.sv
`timescale 1ns/1ps
// Bench for param_flash_loader: SPI flash model per instance plus a cycle-by-cycle SRAM write scoreboard.
module tb_param_flash_loader;
`ifdef PARAM_CHECKSUM_EN
  localparam int NI    = 3;
  localparam int CKS_W = 1;
`else
  localparam int NI    = 2;
  localparam int CKS_W = 0;
`endif
  localparam int WN_T [3] = '{16, 1, 2};
  localparam int SD_T [3] = '{2, 1, 1};
  localparam int MEMW     = 33;
  localparam int BUDGET   = 5000;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          rst;
  logic [NI-1:0] start;
  logic          cs_n_a [NI];
  logic          sck_a  [NI];
  logic          mosi_a [NI];
  logic          csen_a [NI];
  logic          wren_a [NI];
  logic          rden_a [NI];
  logic          pulse_a[NI];
  logic          busy_a [NI];
  logic          cerr_a [NI];
  logic [17:0]   addr_a [NI];
  logic [15:0]   data_a [NI];
  logic [31:0]   cmd_a  [NI];
  logic [15:0]   mem    [NI][MEMW];

  int          vec, bad;
  int          wr_cnt[NI], pulse_cnt[NI], exp_idx[NI];
  logic        prev_cs[NI], prev_pulse[NI];
  logic [15:0] log_d[NI][MEMW];

  // Flash byte stream: byte 2n/2n+1 = high/low byte of mem word n, starting at the commanded address.
  function automatic logic stream_bit(int i, logic [31:0] c, int k);
    int w;
    w = int'((c[23:0] - 24'h0F0000) >> 1) + k / 16;
    if (c[31:24] != 8'h03 || w >= MEMW) return 1'b1;
    return mem[i][w][15 - (k % 16)];
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    param_flash_loader_if bus_i ();
    logic        miso = 1'b0;
    logic [31:0] cmd  = '0;
    int          cnt  = 0;

    param_flash_loader #(
      .FLASH_BASE_ADDR(24'h0F0000),
      .WORD_NUM       (WN_T[gi]),
      .SCK_DIV        (SD_T[gi])
    ) dut (
      .i_clk_50m          (clk),
      .i_rst              (rst),
      .i_load_start       (start[gi]),
      .bus                (bus_i),
      .o_read_complete_sig(pulse_a[gi]),
      .o_busy             (busy_a[gi]),
      .o_cks_err          (cerr_a[gi])
    );

    assign bus_i.i_spi_miso = miso;
    assign cs_n_a[gi]  = bus_i.o_spi_cs_n;
    assign sck_a[gi]   = bus_i.o_spi_sck;
    assign mosi_a[gi]  = bus_i.o_spi_mosi;
    assign csen_a[gi]  = bus_i.o_sram_csen;
    assign wren_a[gi]  = bus_i.o_sram_wren;
    assign rden_a[gi]  = bus_i.o_sram_rden;
    assign addr_a[gi]  = bus_i.o_sram_addr;
    assign data_a[gi]  = bus_i.o_sram_data;
    assign cmd_a[gi]   = cmd;

    always @(posedge bus_i.o_spi_sck or posedge bus_i.o_spi_cs_n) begin
      if (bus_i.o_spi_cs_n) cnt <= 0;
      else begin
        if (cnt < 32) cmd <= {cmd[30:0], bus_i.o_spi_mosi};
        cnt <= cnt + 1;
      end
    end

    always @(negedge bus_i.o_spi_sck or posedge bus_i.o_spi_cs_n) begin
      if (bus_i.o_spi_cs_n) miso <= 1'b0;
      else if (cnt >= 32)   miso <= stream_bit(gi, cmd, cnt - 32);
    end
  end

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h, want %0h", name, inst, act, exp);
    end
  endtask

  function automatic int lat_exp(int i);
    return 1 + 64 * SD_T[i] + WN_T[i] * (32 * SD_T[i] + 2) + CKS_W * 32 * SD_T[i];
  endfunction

  task automatic set_mem(int i, logic [15:0] seed);
    logic [15:0] sum;
    sum = '0;
    for (int k = 0; k < MEMW; k++) mem[i][k] = '0;
    for (int k = 0; k < WN_T[i]; k++) begin
      mem[i][k] = (k == 0) ? 16'h0001 : (k == 1) ? 16'h1234 : seed ^ 16'(k * 16'h0F1D);
      sum = sum + mem[i][k];
    end
    mem[i][WN_T[i]] = 16'h0000 - sum;
  endtask

  // Scoreboard: the k-th SRAM write of a transfer must go to address k with flash word k.
  task automatic compare_loop();
    int e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk("rden_high", i, 32'(rden_a[i]), 32'd1);
        if (prev_cs[i] && !cs_n_a[i]) exp_idx[i] = 0;
        if (csen_a[i]) begin
          e = (exp_idx[i] < MEMW) ? exp_idx[i] : MEMW - 1;
          chk("wr_wren", i, 32'(wren_a[i]), 32'd0);
          chk("wr_addr", i, 32'(addr_a[i]), 32'(exp_idx[i]));
          chk("wr_data", i, 32'(data_a[i]), 32'(mem[i][e]));
          chk("wr_cs_low", i, 32'(cs_n_a[i]), 32'd0);
          chk("wr_in_range", i, 32'(exp_idx[i] < WN_T[i]), 32'd1);
          log_d[i][e] = data_a[i];
          exp_idx[i]++;
          wr_cnt[i]++;
        end else begin
          chk("idle_wren", i, 32'(wren_a[i]), 32'd1);
          chk("idle_addr", i, 32'(addr_a[i]), 32'd0);
          chk("idle_data", i, 32'(data_a[i]), 32'd0);
        end
        if (pulse_a[i]) begin
          chk("pulse_all_words", i, 32'(exp_idx[i]), 32'(WN_T[i]));
          chk("pulse_one_cycle", i, 32'(prev_pulse[i]), 32'd0);
          chk("pulse_cs_high", i, 32'(cs_n_a[i]), 32'd1);
          chk("pulse_busy", i, 32'(busy_a[i]), 32'd1);
          pulse_cnt[i]++;
        end
        prev_cs[i]    = cs_n_a[i];
        prev_pulse[i] = pulse_a[i];
      end
    end
  endtask

  task automatic pulse_start(int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  // Waits for busy to drop; lat is the cycle count from the start edge to the complete pulse (-1 if none).
  task automatic wait_idle(int i, output int lat);
    int c;
    c   = 0;
    lat = -1;
    while (busy_a[i] && c < BUDGET) begin
      if (pulse_a[i]) lat = c;
      @(negedge clk);
      c++;
    end
    chk("busy_timeout", i, 32'(busy_a[i]), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_xfer(int i, output int lat, output int dw, output int dp);
    int w0, p0;
    w0 = wr_cnt[i];
    p0 = pulse_cnt[i];
    pulse_start(i);
    wait_idle(i, lat);
    dw = wr_cnt[i] - w0;
    dp = pulse_cnt[i] - p0;
    $display("xfer inst %0d: writes=%0d pulses=%0d latency=%0d cks_err=%0d", i, dw, dp, lat, cerr_a[i]);
  endtask

  task automatic chk_latency(int i, int lat);
    chk("latency_window", i, 32'((lat >= lat_exp(i) - 2) && (lat <= lat_exp(i) + 2)), 32'd1);
  endtask

  initial begin
    int lat, dw, dp, w0, p0, c;
    vec   = 0;
    bad   = 0;
    rst   = 1'b1;
    start = '0;
    for (int i = 0; i < NI; i++) begin
      wr_cnt[i] = 0; pulse_cnt[i] = 0; exp_idx[i] = 0;
      for (int k = 0; k < MEMW; k++) log_d[i][k] = '0;
      set_mem(i, 16'h2000 + 16'(i * 16'h3100));
    end
    repeat (3) @(negedge clk);

    for (int i = 0; i < NI; i++) begin
      chk("rst_cs_n", i, 32'(cs_n_a[i]), 32'd1);
      chk("rst_sck", i, 32'(sck_a[i]), 32'd0);
      chk("rst_mosi", i, 32'(mosi_a[i]), 32'd0);
      chk("rst_csen", i, 32'(csen_a[i]), 32'd0);
      chk("rst_wren", i, 32'(wren_a[i]), 32'd1);
      chk("rst_addr", i, 32'(addr_a[i]), 32'd0);
      chk("rst_data", i, 32'(data_a[i]), 32'd0);
      chk("rst_pulse", i, 32'(pulse_a[i]), 32'd0);
      chk("rst_busy", i, 32'(busy_a[i]), 32'd0);
      chk("rst_cks_err", i, 32'(cerr_a[i]), 32'd0);
    end

    // Start coincident with reset must be dropped.
    start = '1;
    @(negedge clk);
    rst   = 1'b0;
    start = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("start_in_rst_busy", i, 32'(busy_a[i]), 32'd0);
      chk("start_in_rst_cs", i, 32'(cs_n_a[i]), 32'd1);
      prev_cs[i]    = cs_n_a[i];
      prev_pulse[i] = pulse_a[i];
    end

    fork
      compare_loop();
    join_none

    // Default block: 16 words, SCK_DIV=2.
    run_xfer(0, lat, dw, dp);
    chk("a_writes", 0, 32'(dw), 32'd16);
    chk("a_pulses", 0, 32'(dp), 32'd1);
    chk("a_cmd_word", 0, cmd_a[0], 32'h030F0000);
    chk("a_word0", 0, 32'(log_d[0][0]), 32'h0001);
    chk("a_word1", 0, 32'(log_d[0][1]), 32'h1234);
    chk("a_cks_err", 0, 32'(cerr_a[0]), 32'd0);
    chk_latency(0, lat);

    // Single word at the fastest SCK.
    run_xfer(1, lat, dw, dp);
    chk("b_writes", 1, 32'(dw), 32'd1);
    chk("b_pulses", 1, 32'(dp), 32'd1);
    chk("b_word0", 1, 32'(log_d[1][0]), 32'h0001);
`ifdef PARAM_CHECKSUM_EN
    chk("b_latency_literal", 1, 32'((lat >= 129) && (lat <= 133)), 32'd1);
`else
    chk("b_latency_literal", 1, 32'((lat >= 97) && (lat <= 101)), 32'd1);
`endif
    chk_latency(1, lat);

    // A second start during CMD is ignored.
    w0 = wr_cnt[0];
    p0 = pulse_cnt[0];
    pulse_start(0);
    repeat (10) @(negedge clk);
    pulse_start(0);
    wait_idle(0, lat);
    $display("xfer inst 0: double start, writes=%0d pulses=%0d", wr_cnt[0] - w0, pulse_cnt[0] - p0);
    chk("c_writes", 0, 32'(wr_cnt[0] - w0), 32'd16);
    chk("c_pulses", 0, 32'(pulse_cnt[0] - p0), 32'd1);

    // Reset while word 5 is being read aborts the transfer without a pulse.
    w0 = wr_cnt[0];
    p0 = pulse_cnt[0];
    pulse_start(0);
    c = 0;
    while ((wr_cnt[0] - w0) < 5 && c < BUDGET) begin
      @(negedge clk);
      c++;
    end
    chk("d_words_before_rst", 0, 32'(wr_cnt[0] - w0), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    chk("d_rst_cs_n", 0, 32'(cs_n_a[0]), 32'd1);
    chk("d_rst_sck", 0, 32'(sck_a[0]), 32'd0);
    chk("d_rst_wren", 0, 32'(wren_a[0]), 32'd1);
    chk("d_rst_busy", 0, 32'(busy_a[0]), 32'd0);
    chk("d_rst_pulse", 0, 32'(pulse_a[0]), 32'd0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    $display("xfer inst 0: aborted by reset, writes=%0d pulses=%0d", wr_cnt[0] - w0, pulse_cnt[0] - p0);
    chk("d_no_pulse", 0, 32'(pulse_cnt[0] - p0), 32'd0);
    set_mem(0, 16'hC300);
    run_xfer(0, lat, dw, dp);
    chk("d_rerun_writes", 0, 32'(dw), 32'd16);
    chk("d_rerun_pulses", 0, 32'(dp), 32'd1);
    chk("d_rerun_last", 0, 32'(log_d[0][15]), 32'(16'hC300 ^ 16'(15 * 16'h0F1D)));

`ifdef PARAM_CHECKSUM_EN
    // Checksum block: 0x0001 + 0x0002 + 0xFFFD = 0 passes; 0xFFFC fails.
    mem[2][0] = 16'h0001;
    mem[2][1] = 16'h0002;
    mem[2][2] = 16'hFFFD;
    run_xfer(2, lat, dw, dp);
    chk("e_good_writes", 2, 32'(dw), 32'd2);
    chk("e_good_pulses", 2, 32'(dp), 32'd1);
    chk("e_good_cks_err", 2, 32'(cerr_a[2]), 32'd0);
    chk_latency(2, lat);
    mem[2][2] = 16'hFFFC;
    run_xfer(2, lat, dw, dp);
    chk("e_bad_writes", 2, 32'(dw), 32'd2);
    chk("e_bad_pulses", 2, 32'(dp), 32'd0);
    chk("e_bad_cks_err", 2, 32'(cerr_a[2]), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
